// File: rtl/mc_alu_if.sv
// Start/busy/done handshake bundle between the MIPS control path and mc_alu.
// master drives the request; slave (the ALU) returns status and results.
interface mc_alu_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic             zero;
  logic             dz;

  modport master (output start, op, a, b,
                  input  busy, done, result, hi, zero, dz);
  modport slave  (input  start, op, a, b,
                  output busy, done, result, hi, zero, dz);
endinterface

// File: rtl/mc_alu.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative unsigned
// shift-add multiply and restoring divide, both writing HI.
module mc_alu #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  mc_alu_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_AND  = 4'd1;
  localparam logic [3:0] OP_OR   = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_SLT  = 4'd4;
  localparam logic [3:0] OP_SLTU = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NOR  = 4'd7;
  localparam logic [3:0] OP_MULU = 4'd8;
  localparam logic [3:0] OP_DIVU = 4'd9;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] wk_hi, wk_lo, opnd;
  logic             last;
  logic [WIDTH-1:0] res_sc;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0] mul_hi_nxt, mul_lo_nxt, div_rem_nxt, div_quo_nxt;

  function automatic logic [WIDTH-1:0] alu_op(input logic [3:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    sa = a;
    sb = b;
    case (op)
      OP_ADD:  alu_op = a + b;
      OP_AND:  alu_op = a & b;
      OP_OR:   alu_op = a | b;
      OP_SUB:  alu_op = a - b;
      OP_SLT:  alu_op = WIDTH'(sa < sb);
      OP_SLTU: alu_op = WIDTH'(a < b);
      OP_XOR:  alu_op = a ^ b;
      OP_NOR:  alu_op = ~(a | b);
      default: alu_op = '0;
    endcase
  endfunction

  // One iteration step: wk_hi holds partial product / partial remainder,
  // wk_lo the multiplier being shifted out / dividend becoming the quotient.
  always_comb begin
    res_sc     = alu_op(bus.op, bus.a, bus.b);
    mul_sum    = {1'b0, wk_hi} + (wk_lo[0] ? {1'b0, opnd} : '0);
    mul_hi_nxt = mul_sum[WIDTH:1];
    mul_lo_nxt = {mul_sum[0], wk_lo[WIDTH-1:1]};
    div_shift  = {wk_hi, wk_lo[WIDTH-1]};
    div_diff   = div_shift - {1'b0, opnd};
    if (!div_diff[WIDTH]) begin
      div_rem_nxt = div_diff[WIDTH-1:0];
      div_quo_nxt = {wk_lo[WIDTH-2:0], 1'b1};
    end else begin
      div_rem_nxt = div_shift[WIDTH-1:0];
      div_quo_nxt = {wk_lo[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bus.busy  = 1'b0;
    last      = (cnt == CNT_W'(1));
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.op == OP_MULU)                       state_nxt = S_MUL;
          else if (bus.op == OP_DIVU && bus.b != '0)   state_nxt = S_DIV;
        end
      end
      S_MUL, S_DIV: begin
        bus.busy = 1'b1;
        if (last) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Iteration registers carry no reset; they are reloaded on every accept.
  always_ff @(posedge clk) begin
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          cnt   <= CNT_W'(WIDTH);
          wk_hi <= '0;
          if (bus.op == OP_MULU) begin
            wk_lo <= bus.b;
            opnd  <= bus.a;
          end else begin
            wk_lo <= bus.a;
            opnd  <= bus.b;
          end
        end
      end
      S_MUL: begin
        wk_hi <= mul_hi_nxt;
        wk_lo <= mul_lo_nxt;
        cnt   <= cnt - CNT_W'(1);
      end
      S_DIV: begin
        wk_hi <= div_rem_nxt;
        wk_lo <= div_quo_nxt;
        cnt   <= cnt - CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.done   <= 1'b0;
      bus.result <= '0;
      bus.hi     <= '0;
      bus.zero   <= 1'b0;
      bus.dz     <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start && bus.op != OP_MULU) begin
            if (bus.op == OP_DIVU) begin
              if (bus.b == '0) begin
                bus.result <= '1;
                bus.hi     <= bus.a;
                bus.zero   <= 1'b0;
                bus.dz     <= 1'b1;
                bus.done   <= 1'b1;
              end
            end else begin
              bus.result <= res_sc;
              bus.zero   <= (res_sc == '0);
              bus.dz     <= 1'b0;
              bus.done   <= 1'b1;
            end
          end
        end
        S_MUL: begin
          if (last) begin
            bus.result <= mul_lo_nxt;
            bus.hi     <= mul_hi_nxt;
            bus.zero   <= (mul_lo_nxt == '0);
            bus.dz     <= 1'b0;
            bus.done   <= 1'b1;
          end
        end
        S_DIV: begin
          if (last) begin
            bus.result <= div_quo_nxt;
            bus.hi     <= div_rem_nxt;
            bus.zero   <= (div_quo_nxt == '0);
            bus.dz     <= 1'b0;
            bus.done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
